// File: rtl/mult_req_scheduler_if.sv
// Requester/response handshake bundle for mult_req_scheduler.
// The master side is the requesters plus the consumer; the slave side is the scheduler.
interface mult_req_scheduler_if #(
  parameter int WIDTH = 8
);
  logic               req0_valid;
  logic               req0_ready;
  logic [WIDTH-1:0]   req0_a;
  logic [WIDTH-1:0]   req0_b;
  logic               req1_valid;
  logic               req1_ready;
  logic [WIDTH-1:0]   req1_a;
  logic [WIDTH-1:0]   req1_b;
  logic               rsp_valid;
  logic               rsp_ready;
  logic               rsp_id;
  logic [2*WIDTH-1:0] rsp_p;

  modport master (
    output req0_valid, req0_a, req0_b,
    output req1_valid, req1_a, req1_b,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_p
  );

  modport slave (
    input  req0_valid, req0_a, req0_b,
    input  req1_valid, req1_a, req1_b,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_p
  );
endinterface

// File: rtl/mult_req_scheduler.sv
// Round-robin scheduler sharing one multi-cycle signed multiplier between two
// requesters; one operation is outstanding at a time.
module mult_req_scheduler #(
  parameter int WIDTH = 8,
  parameter int LAT   = 2,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mult_req_scheduler_if.slave  bus,
  output logic [WIDTH-1:0]     dp_a,
  output logic [WIDTH-1:0]     dp_b,
  input  logic [2*WIDTH-1:0]   dp_p,
  output logic                 busy,
  output logic [CNT_W-1:0]     op_count
);

  typedef enum logic [1:0] {
    IDLE,
    COMPUTE,
    RESP
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

  state_t     state;
  logic [3:0] cnt;
  logic       last_grant;
  logic       id;
  logic       grant;

  // With both requesters valid, the one not served last wins.
  always_comb begin
    grant = 1'b0;
    if (bus.req0_valid && bus.req1_valid) grant = ~last_grant;
    else if (bus.req1_valid)              grant = 1'b1;
  end

  assign bus.req0_ready = (state == IDLE) && bus.req0_valid && !grant;
  assign bus.req1_ready = (state == IDLE) && bus.req1_valid &&  grant;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      last_grant    <= 1'b1;
      id            <= 1'b0;
      dp_a          <= '0;
      dp_b          <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_id    <= 1'b0;
      bus.rsp_p     <= '0;
      busy          <= 1'b0;
      op_count      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req0_ready || bus.req1_ready) begin
            dp_a       <= grant ? bus.req1_a : bus.req0_a;
            dp_b       <= grant ? bus.req1_b : bus.req0_b;
            id         <= grant;
            last_grant <= grant;
            cnt        <= CNT_INIT;
            busy       <= 1'b1;
            state      <= COMPUTE;
          end
        end
        COMPUTE: begin
          if (cnt == '0) begin
            bus.rsp_p     <= dp_p;
            bus.rsp_id    <= id;
            bus.rsp_valid <= 1'b1;
            state         <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            op_count      <= op_count + CNT_W'(1);
            busy          <= 1'b0;
            state         <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_req_scheduler.sv
// Self-checking bench for mult_req_scheduler: directed and randomized operations
// checked against a round-robin / integer-multiply reference model.
module tb_mult_req_scheduler;
  localparam int W   = 8;
  localparam int LAT = 2;
  localparam int CW  = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mult_req_scheduler_if #(.WIDTH(W)) bus ();

  logic [W-1:0]   dp_a;
  logic [W-1:0]   dp_b;
  logic [2*W-1:0] dp_p;
  logic           busy;
  logic [CW-1:0]  op_count;

  // Shared multiplier datapath: signed, combinational.
  assign dp_p = $signed(dp_a) * $signed(dp_b);

  mult_req_scheduler #(.WIDTH(W), .LAT(LAT), .CNT_W(CW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .dp_a     (dp_a),
    .dp_b     (dp_b),
    .dp_p     (dp_p),
    .busy     (busy),
    .op_count (op_count)
  );

  int          checks = 0;
  int          passed = 0;
  int          model_cnt = 0;
  bit          model_last = 1'b1;
  logic [15:0] got_p;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [15:0] ref_mul(input logic [7:0] x, input logic [7:0] y);
    int p;
    p = int'($signed(x)) * int'($signed(y));
    return p[15:0];
  endfunction

  // One complete operation; called at #1 after a rising edge with the DUT idle.
  task automatic do_op(input bit v0, input bit v1,
                       input logic [7:0] a0, input logic [7:0] b0,
                       input logic [7:0] a1, input logic [7:0] b1,
                       input int hold);
    bit          g;
    logic [7:0]  ea, eb;
    logic [15:0] ep;
    g  = (v0 && v1) ? ~model_last : v1;
    ea = g ? a1 : a0;
    eb = g ? b1 : b0;
    ep = ref_mul(ea, eb);
    bus.req0_valid = v0; bus.req0_a = a0; bus.req0_b = b0;
    bus.req1_valid = v1; bus.req1_a = a1; bus.req1_b = b1;
    bus.rsp_ready  = 1'b0;
    #1;
    check("req0_ready_idle", bus.req0_ready, !g);
    check("req1_ready_idle", bus.req1_ready, g);
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    model_last     = g;
    bus.rsp_ready  = 1'b1;
    check("busy_after_accept", busy, 1);
    check("dp_a_latched", dp_a, ea);
    check("dp_b_latched", dp_b, eb);
    for (int c = 1; c <= LAT; c++) begin
      @(posedge clk); #1;
      if (c < LAT) begin
        check("rsp_valid_early", bus.rsp_valid, 0);
        check("op_count_compute", op_count, model_cnt);
        check("dp_a_stable", dp_a, ea);
      end else begin
        check("rsp_valid_lat", bus.rsp_valid, 1);
        check("rsp_p", bus.rsp_p, ep);
        check("rsp_id", bus.rsp_id, g);
      end
    end
    got_p = bus.rsp_p;
    bus.rsp_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      bus.req0_valid = 1'($urandom); bus.req0_a = 8'($urandom); bus.req0_b = 8'($urandom);
      bus.req1_valid = 1'($urandom); bus.req1_a = 8'($urandom); bus.req1_b = 8'($urandom);
      #1;
      check("bp_rsp_valid", bus.rsp_valid, 1);
      check("bp_rsp_p", bus.rsp_p, ep);
      check("bp_rsp_id", bus.rsp_id, g);
      check("bp_req0_ready", bus.req0_ready, 0);
      check("bp_req1_ready", bus.req1_ready, 0);
      check("bp_busy", busy, 1);
      @(posedge clk); #1;
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.rsp_ready  = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    model_cnt = (model_cnt + 1) % (1 << CW);
    check("op_count_done", op_count, model_cnt);
    check("rsp_valid_cleared", bus.rsp_valid, 0);
    check("busy_cleared", busy, 0);
  endtask

  initial begin
    int  seen;
    bit  eid;
    bit  r0, r1;
    rst_n = 1'b0;
    bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0;
    bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0;
    bus.rsp_ready  = 1'b0;

    // Reset state and combinational ready during reset.
    #12;
    check("rst_busy", busy, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_p", bus.rsp_p, 0);
    check("rst_rsp_id", bus.rsp_id, 0);
    check("rst_dp_a", dp_a, 0);
    check("rst_dp_b", dp_b, 0);
    check("rst_op_count", op_count, 0);
    bus.req1_valid = 1'b1; #1;
    check("rst_req1_only", bus.req1_ready, 1);
    bus.req0_valid = 1'b1; #1;
    check("rst_both_req0", bus.req0_ready, 1);
    check("rst_both_req1", bus.req1_ready, 0);
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Single operation: -3 * 7.
    do_op(1'b1, 1'b0, 8'hFD, 8'h07, 8'h00, 8'h00, 0);
    check("single_p_literal", got_p, 16'hFFEB);

    // Valid that drops before any edge cancels with no side effect.
    bus.req0_valid = 1'b1; bus.req0_a = 8'h11; bus.req0_b = 8'h22; #1;
    check("cancel_ready", bus.req0_ready, 1);
    #2 bus.req0_valid = 1'b0;
    @(posedge clk); #1;
    check("cancel_busy", busy, 0);
    check("cancel_dp_a_kept", dp_a, 8'hFD);
    check("cancel_op_count", op_count, model_cnt);

    // Backpressure: five cycles of rsp_ready low in RESP.
    do_op(1'b0, 1'b1, 8'h00, 8'h00, 8'($urandom), 8'($urandom), 5);

    // Contention from a fresh reset with both requesters held valid.
    rst_n = 1'b0; #2 rst_n = 1'b1;
    model_last = 1'b1; model_cnt = 0;
    bus.req0_valid = 1'b1; bus.req0_a = 8'd1; bus.req0_b = 8'd2;
    bus.req1_valid = 1'b1; bus.req1_a = 8'd3; bus.req1_b = 8'd4;
    bus.rsp_ready  = 1'b1;
    seen = 0;
    for (int cyc = 0; cyc < 40 && seen < 3; cyc++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        eid = ~model_last;
        check("contend_id", bus.rsp_id, eid);
        check("contend_p", bus.rsp_p, eid ? ref_mul(8'd3, 8'd4) : ref_mul(8'd1, 8'd2));
        model_last = eid;
        model_cnt++;
        seen++;
        if (seen == 3) begin
          bus.req0_valid = 1'b0;
          bus.req1_valid = 1'b0;
        end
      end
    end
    check("contend_responses", seen, 3);
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    check("contend_op_count", op_count, model_cnt);
    check("contend_idle", busy, 0);

    // Reset during COMPUTE aborts the operation.
    bus.req1_valid = 1'b1; bus.req1_a = 8'h55; bus.req1_b = 8'h22;
    @(posedge clk); #1;
    bus.req1_valid = 1'b0;
    @(posedge clk); #1;
    check("midop_busy_before", busy, 1);
    rst_n = 1'b0; #1;
    check("midop_rsp_valid", bus.rsp_valid, 0);
    check("midop_busy", busy, 0);
    check("midop_dp_a", dp_a, 0);
    check("midop_op_count", op_count, 0);
    bus.rsp_ready = 1'b1;
    #2 rst_n = 1'b1;
    model_cnt = 0; model_last = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("midop_no_rsp", bus.rsp_valid, 0);
    end
    bus.rsp_ready = 1'b0;

    // Sixteen randomized operations wrap the 4-bit counter; one is 0x80*0x80.
    for (int i = 0; i < 16; i++) begin
      if (i == 7) begin
        do_op(1'b1, 1'b0, 8'h80, 8'h80, 8'h00, 8'h00, 0);
        check("edge_0x80_literal", got_p, 16'h4000);
      end else begin
        r0 = 1'($urandom);
        r1 = 1'($urandom);
        if (!r0 && !r1) r0 = 1'b1;
        do_op(r0, r1, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
              int'($urandom_range(0, 2)));
      end
    end
    check("wrap_op_count", op_count, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/mult_req_scheduler.md
MULT_REQ_SCHEDULER -- requirements
Module: mult_req_scheduler

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand width in bits; product width is 2*WIDTH.
REQ-002 SHALL have parameter LAT, default 2: cycles allowed for the shared multiplier datapath to settle; legal range 1..15.
REQ-003 SHALL have parameter CNT_W, default 16: width of the completed-operation counter.
REQ-004 SHALL have one clock and an asynchronous, active-low reset; the ports are clk and rst_n.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 req0_valid / req1_valid  input  1 each  requester has an operand pair pending.
REQ-008 req0_ready / req1_ready  output  1 each  scheduler accepts that requester this cycle.
REQ-009 req0_a, req0_b, req1_a, req1_b  input  WIDTH each  signed operands.
REQ-010 dp_a, dp_b  output  WIDTH each  registered operands driven to the shared multiplier datapath.
REQ-011 dp_p  input  2*WIDTH  signed product returned by the shared datapath (combinational function of dp_a, dp_b).
REQ-012 rsp_valid  output  1  result available.
REQ-013 rsp_ready  input  1  consumer accepts the result.
REQ-014 rsp_id  output  1  index of the requester that owns rsp_p.
REQ-015 rsp_p  output  2*WIDTH  captured product.
REQ-016 busy  output  1  high whenever state is not IDLE.
REQ-017 op_count  output  CNT_W  number of completed response handshakes, modulo 2^CNT_W.

Function
REQ-018 SHALL implement an FSM with states IDLE, COMPUTE and RESP, and SHALL allow one operation outstanding at a time.
REQ-019 IDLE: grant = the only valid requester; if both are valid, grant = the requester not granted last (round-robin); reqN_ready = (state==IDLE) & reqN_valid & (grant==N), combinational.
REQ-020 After reset the last-grant pointer SHALL be 1, so req0 wins the first simultaneous contest.
REQ-021 On an accept edge (reqN_valid & reqN_ready): latch reqN_a/b into dp_a/dp_b; record id=N; update the last-grant pointer to N; load the counter with LAT-1; go to COMPUTE.
REQ-022 COMPUTE: dp_a/dp_b SHALL hold stable; both ready outputs SHALL be 0; the counter decrements each cycle.
REQ-023 On the COMPUTE edge where the counter is 0: capture dp_p into rsp_p and id into rsp_id, set rsp_valid, go to RESP. rsp_valid therefore rises exactly LAT cycles after the accept edge.
REQ-024 RESP: rsp_valid, rsp_p and rsp_id SHALL hold stable until rsp_valid & rsp_ready is seen at a rising edge.
REQ-025 On that handshake edge: clear rsp_valid, increment op_count (wrapping from 2^CNT_W-1 to 0), go to IDLE. The next accept can occur no earlier than the following edge.
REQ-026 dp_a/dp_b SHALL retain their last values in IDLE and RESP.
REQ-027 Requester inputs that change while not accepted SHALL be ignored; a valid that drops before acceptance SHALL cancel without side effects.
REQ-028 rsp_ready asserted while rsp_valid=0 SHALL have no effect.

Reset
REQ-029 While rst_n=0, regardless of clk: state=IDLE, rsp_valid=0, rsp_p=0, rsp_id=0, dp_a=0, dp_b=0, op_count=0, counter=0, last-grant=1.
REQ-030 Consequently busy=0 and both ready outputs follow REQ-019 (combinational from valid) during reset.
REQ-031 A reset asserted during COMPUTE or RESP SHALL abort the operation; no response is produced for it and op_count is unchanged from 0.

Verification (WIDTH=8, LAT=2, CNT_W=4, bench models dp_p = dp_a*dp_b signed)
REQ-032 Single op: req0 a=0xFD (-3), b=0x07 accepted at edge T -> rsp_valid rises at edge T+2 with rsp_p=0xFFEB, rsp_id=0; with rsp_ready=1, op_count=1 after the following edge.
REQ-033 Contention: req0 and req1 both continuously valid (1*2 and 3*4) -> responses in order id0 p=0x0002, then id1 p=0x000C, then id0 again; no requester is granted twice in a row while both are valid.
REQ-034 Backpressure: rsp_ready held low 5 cycles in RESP -> rsp_valid=1, rsp_p and rsp_id constant, req0_ready=req1_ready=0, busy=1 throughout.
REQ-035 Reset mid-op: rst_n pulsed low during COMPUTE -> immediately rsp_valid=0, busy=0, dp_a=0, op_count=0; no response is produced afterward.
REQ-036 Wrap: 16 completed ops -> op_count returns to 0; edge case a=b=0x80 -> rsp_p=0x4000.
